seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter for the sequence-detector family: accepts a parallel pattern word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times. It generates the serial `in` stream consumed by the Mealy/Moore "101" detectors. It also keeps its own overlapping-"101" count of the emitted stream, so a bench can check a downstream detector against it.

## Interface
- `WIDTH`, 16: pattern length in bits (≥ 3).
- `CNT_W`, 8: width of the repeat count and of the match counter.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load_valid` input 1: pattern offered.
- `load_ready` output 1: block can accept a pattern.
- `load_data` input WIDTH: pattern, bit WIDTH-1 sent first.
- `load_repeat` input CNT_W: number of passes; 0 is treated as 1.
- `out` output 1: serial bit (drives detector `in`).
- `out_valid` output 1: `out` carries a pattern bit this cycle.
- `busy` output 1: transaction in progress (SHIFT or DONE).
- `done` output 1: one-cycle pulse at the end of a transaction.
- `match_cnt` output CNT_W: overlapping "101" occurrences emitted in the current or last transaction.

## Operation
- States:
  - IDLE: `load_ready`=1, `busy`=0.
  - SHIFT: emitting bits.
  - DONE: one cycle, `done`=1, `load_ready`=0.
- Accept: `load_valid`&&`load_ready` at a rising edge in IDLE.
  - Latches `load_data` into the shift register.
  - Latches the pass count as max(`load_repeat`,1).
  - Clears the bit index, `match_cnt` and the 2-bit history.
  - Moves to SHIFT.
- SHIFT:
  - Each cycle: `out`=current MSB, `out_valid`=1.
  - Shift register rotates left by one, so the pattern is preserved for the next pass.
  - Bit index wraps 0..WIDTH-1. On a wrap, the remaining-pass count decrements.
  - The last bit of the last pass moves the FSM to DONE.
- DONE moves to IDLE unconditionally.
- Passes concatenate with no gap bits. The history carries across pass boundaries, so "101" spanning a boundary counts.
- Match count:
  - On every cycle with `out_valid`=1, if history (bit n-2, bit n-1) = (1,0) and `out`=1, `match_cnt` increments at that edge.
  - Saturates at 2^CNT_W-1.
  - Holds after DONE until the next accept.
- `load_valid` outside IDLE is ignored. A pending load is taken on the first IDLE cycle.
- `out`=0 whenever `out_valid`=0.

## Timing
- Reset values: `out`=0, `out_valid`=0, `load_ready`=1, `busy`=0, `done`=0, `match_cnt`=0, state IDLE, history 00.
- All outputs are registered.
- Accept at edge k:
  - first bit valid in cycle k+1;
  - bit j of the stream (0-based) in cycle k+1+j;
  - last bit in cycle k+WIDTH·P, where P = number of passes;
  - `done`=1 in cycle k+WIDTH·P+1;
  - `load_ready`=1 again in cycle k+WIDTH·P+2.
- `match_cnt` reflects a match ending on bit j from cycle k+2+j. The final value is valid in the DONE cycle.
- Back-to-back transactions: minimum period WIDTH·P+2 cycles.
- `rst` mid-transaction: the next cycle shows reset values. No `done` is issued and the pattern is discarded.
- `rst` together with `load_valid`: reset wins and nothing is accepted.

## Test plan
All scenarios use WIDTH=16, CNT_W=8.
1. Reset: hold `rst` 2 cycles → `out`=0, `out_valid`=0, `load_ready`=1, `busy`=0, `done`=0, `match_cnt`=0.
2. Single pass: load 16'hB550 with `load_repeat`=1 at edge k.
   - Stream is 1011010101010000 in cycles k+1..k+16.
   - `done` at k+17 with `match_cnt`=5.
   - `load_ready` at k+18.
3. Boundary overlap: load 16'h8002 with `load_repeat`=3.
   - 48 bits; `done` at k+49.
   - `match_cnt`=2 (both matches span a pass boundary).
4. Repeat zero and saturation:
   - 16'h8002 with `load_repeat`=0 → exactly 16 bits, `match_cnt`=0.
   - 16'hAAAA with `load_repeat`=255 → `match_cnt`=255 (saturated; raw count 2039).
5. Handshake: pulse `load_valid` with a new value during SHIFT and during DONE.
   - Ignored; `load_ready`=0 throughout; the stream is unchanged.
   - With `load_valid` held high, the next load is accepted in the first IDLE cycle.
6. Mid-stream reset: assert `rst` at bit 5 of 16'hB550.
   - Next cycle shows reset values; no `done`.
   - A following load of 16'hAAAA with `load_repeat`=1 gives `match_cnt`=7.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial output bundle for the pattern transmitter.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_repeat;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output load_valid, load_data, load_repeat,
    input  load_ready, out, out_valid, busy, done, match_cnt
  );

  modport slave (
    input  load_valid, load_data, load_repeat,
    output load_ready, out, out_valid, busy, done, match_cnt
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first for a
// programmable number of back-to-back passes and counts overlapping "101"
// occurrences in the emitted stream.
module seq_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_tx_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [IW-1:0]    IDX_LAST = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] passes;
  logic [CNT_W-1:0] match;
  logic [1:0]       hist;
  logic             out_r, ov_r, rdy_r, busy_r, done_r;

  logic hit, last_bit, last_pass;

  // Match detect on the bit currently on the wire against the two before it.
  always_comb begin
    hit       = ov_r && (hist == 2'b10) && out_r;
    last_bit  = (idx == IDX_LAST);
    last_pass = (passes == CNT_W'(1));
  end

  // Transaction FSM, rotating shift register, pass/bit counters and match count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sr     <= '0;
      idx    <= '0;
      passes <= '0;
      match  <= '0;
      hist   <= 2'b00;
      out_r  <= 1'b0;
      ov_r   <= 1'b0;
      rdy_r  <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_valid) begin
            // First bit goes straight to the output register; the shift
            // register is pre-rotated so its MSB is always the next bit.
            out_r  <= bus.load_data[WIDTH-1];
            sr     <= {bus.load_data[WIDTH-2:0], bus.load_data[WIDTH-1]};
            ov_r   <= 1'b1;
            idx    <= '0;
            passes <= (bus.load_repeat == '0) ? CNT_W'(1) : bus.load_repeat;
            match  <= '0;
            hist   <= 2'b00;
            rdy_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // History runs across pass boundaries so spanning matches count.
          hist <= {hist[0], out_r};
          if (hit && (match != CNT_MAX)) match <= match + CNT_W'(1);
          if (last_bit && last_pass) begin
            out_r  <= 1'b0;
            ov_r   <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            out_r <= sr[WIDTH-1];
            sr    <= {sr[WIDTH-2:0], sr[WIDTH-1]};
            if (last_bit) begin
              idx    <= '0;
              passes <= passes - CNT_W'(1);
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_DONE: begin
          rdy_r  <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          rdy_r  <= 1'b1;
          busy_r <= 1'b0;
          out_r  <= 1'b0;
          ov_r   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready = rdy_r;
  assign bus.out        = out_r;
  assign bus.out_valid  = ov_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.match_cnt  = match;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed scenarios plus random traffic, checked
// every cycle against a queue-based cycle model built from the stream rules.
module tb_seq_pattern_tx;
  localparam int W  = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  seq_pattern_tx #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Expected outputs for one cycle.
  typedef struct {
    bit o, ov, rdy, bsy, dn;
    int m;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{o:0, ov:0, rdy:1, bsy:0, dn:0, m:0};

  function automatic exp_t idle_rec(input int m);
    exp_t e;
    e = '{o:0, ov:0, rdy:1, bsy:0, dn:0, m:m};
    return e;
  endfunction

  // Expand an accepted load into the full list of future output cycles.
  task automatic build(input logic [W-1:0] d, input logic [CW-1:0] r);
    int p, n, cnt;
    bit bits[$];
    exp_t e;
    p = (r == 0) ? 1 : int'(r);
    for (int i = 0; i < p; i++)
      for (int b = W - 1; b >= 0; b--) bits.push_back(d[b]);
    n = bits.size();
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      e = '{o:bits[j], ov:1, rdy:0, bsy:1, dn:0, m:(cnt > CMAX ? CMAX : cnt)};
      q.push_back(e);
      if (j >= 2 && bits[j-2] && !bits[j-1] && bits[j]) cnt++;
    end
    e = '{o:0, ov:0, rdy:0, bsy:1, dn:1, m:(cnt > CMAX ? CMAX : cnt)};
    q.push_back(e);
  endtask

  // Model advance at each active edge.
  always @(posedge clk) begin
    exp_t nxt;
    if (rst) begin
      q.delete();
      nxt = idle_rec(0);
    end else if (q.size() == 0 && cur.rdy && bus.load_valid) begin
      build(bus.load_data, bus.load_repeat);
      nxt = q.pop_front();
    end else if (q.size() > 0) begin
      nxt = q.pop_front();
    end else begin
      nxt = idle_rec(cur.m);
    end
    cur <= nxt;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out",        bus.out,        cur.o);
      chk("out_valid",  bus.out_valid,  cur.ov);
      chk("load_ready", bus.load_ready, cur.rdy);
      chk("busy",       bus.busy,       cur.bsy);
      chk("done",       bus.done,       cur.dn);
      chk("match_cnt",  bus.match_cnt,  cur.m);
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, " out"},        bus.out, 0);
    chk({nm, " out_valid"},  bus.out_valid, 0);
    chk({nm, " load_ready"}, bus.load_ready, 1);
    chk({nm, " busy"},       bus.busy, 0);
    chk({nm, " done"},       bus.done, 0);
    chk({nm, " match_cnt"},  bus.match_cnt, 0);
  endtask

  // Issue one load from an idle cycle and follow it to done.
  task automatic run_txn(input logic [W-1:0] d, input logic [CW-1:0] r,
                         input int exp_len, input int exp_m, input string nm,
                         output logic [W-1:0] s);
    int t, nb;
    bit got_done;
    bus.load_valid = 1'b1; bus.load_data = d; bus.load_repeat = r;
    @(negedge clk);
    bus.load_valid = 1'b0;
    t = 1; nb = 0; s = '0; got_done = 1'b0;
    while (t <= 5000) begin
      if (bus.out_valid) begin nb++; s = {s[W-2:0], bus.out}; end
      if (bus.done) begin got_done = 1'b1; break; end
      @(negedge clk);
      t++;
    end
    chk({nm, " done seen"},   got_done, 1);
    chk({nm, " done cycle"},  t, exp_len + 1);
    chk({nm, " bit count"},   nb, exp_len);
    chk({nm, " match"},       bus.match_cnt, exp_m);
    chk({nm, " model match"}, cur.m, exp_m);
    @(negedge clk);
    chk({nm, " ready after"}, bus.load_ready, 1);
  endtask

  logic [W-1:0] s;
  int seen;

  initial begin
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_repeat = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Single pass, literal stream and count.
    run_txn(16'hB550, 8'd1, 16, 5, "single", s);
    chk("single stream", s, 16'hB550);

    // Matches that only exist across pass boundaries.
    run_txn(16'h8002, 8'd3, 48, 2, "boundary", s);

    // Zero repeat means one pass; long alternating run saturates.
    run_txn(16'h8002, 8'd0, 16, 0, "rep0", s);
    run_txn(16'hAAAA, 8'd255, 4080, 255, "saturate", s);

    // Loads offered during SHIFT and DONE are ignored; held load taken in IDLE.
    bus.load_valid = 1'b1; bus.load_data = 16'hB550; bus.load_repeat = 8'd1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    s = '0;
    for (int t = 1; t <= 40; t++) begin
      if (t <= 16 && bus.out_valid) s = {s[W-2:0], bus.out};
      if (t == 17) begin
        chk("hs done1", bus.done, 1);
        chk("hs ready in done", bus.load_ready, 0);
      end
      if (t == 18) chk("hs ready idle", bus.load_ready, 1);
      if (t == 19) chk("hs 2nd first bit", {bus.out_valid, bus.out}, 2'b11);
      if (t == 35) begin
        chk("hs done2", bus.done, 1);
        chk("hs match2", bus.match_cnt, 0);
      end
      if (t == 4) begin
        bus.load_valid = 1'b1; bus.load_data = 16'hFFFF; bus.load_repeat = 8'd1;
      end else if (t >= 10 && t <= 18) begin
        bus.load_valid = 1'b1; bus.load_data = 16'h8002; bus.load_repeat = 8'd1;
      end else begin
        bus.load_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("hs stream", s, 16'hB550);

    // Reset in the middle of a pattern.
    bus.load_valid = 1'b1; bus.load_data = 16'hB550; bus.load_repeat = 8'd1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst bit5", {bus.out_valid, bus.out}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("midrst no done", seen, 0);
    run_txn(16'hAAAA, 8'd1, 16, 7, "after rst", s);
    chk("after rst stream", s, 16'hAAAA);

    // Random traffic with occasional resets (and reset colliding with loads).
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.load_valid  = ($urandom_range(0, 2) == 0);
      bus.load_data   = W'($urandom);
      bus.load_repeat = CW'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0;
    bus.load_valid = 1'b0;
    repeat (80) @(negedge clk);
    chk("drain idle", bus.load_ready, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
